swing_capture: RTL and testbench

- Upstream feeder of the bowling power-level display stage.
- Watches a stream of accelerometer magnitude samples and detects one swing: arm on a large sample, track the peak, end on sustained quiet.
- Quantizes the peak into the 3-bit power level `pow_lvl` that the power stage shows on LEDR.
- Emits a one-cycle `pow_valid` strobe per completed swing; the value is held until the next swing completes.

---
 rtl/bowling_pkg.sv | 17 +
 rtl/peak_tracker.sv | 26 ++
 rtl/swing_capture.sv | 136 +++++++++++++
 tb/tb_swing_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bowling_pkg.sv
// Shared types and constants for the bowling swing and power stages.
package bowling_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWING = 1'b1
  } swing_state_t;

  localparam int unsigned POW_W = 3;

  localparam int unsigned DEF_MAG_W        = 8;
  localparam int unsigned DEF_START_THRESH = 64;
  localparam int unsigned DEF_STOP_THRESH  = 32;
  localparam int unsigned DEF_QUIET_CNT    = 4;
  localparam int unsigned DEF_MAX_SAMPLES  = 255;

endpackage

// File: rtl/peak_tracker.sv
// Running unsigned maximum of a sample stream with load, update and clear.
module peak_tracker #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         update,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] peak
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (clear) begin
      peak <= '0;
    end else if (load) begin
      peak <= din;
    end else if (update && (din > peak)) begin
      peak <= din;
    end
  end

endmodule

// File: rtl/swing_capture.sv
// Detects one swing in accelerometer magnitudes and quantizes its peak to a power level.
// Optional swing timeout enabled by defining SWING_TIMEOUT_EN.
module swing_capture
  import bowling_pkg::*;
#(
  parameter int unsigned MAG_W        = DEF_MAG_W,
  parameter int unsigned START_THRESH = DEF_START_THRESH,
  parameter int unsigned STOP_THRESH  = DEF_STOP_THRESH,
  parameter int unsigned QUIET_CNT    = DEF_QUIET_CNT,
  parameter int unsigned MAX_SAMPLES  = DEF_MAX_SAMPLES
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [MAG_W-1:0] accel_mag,
  input  logic             sample_valid,
  input  logic             throw_en,
  output logic [POW_W-1:0] pow_lvl,
  output logic             pow_valid,
  output logic             swinging
);

  localparam int unsigned QW = $clog2(QUIET_CNT + 1);
  localparam logic [MAG_W-1:0] START_T    = MAG_W'(START_THRESH);
  localparam logic [MAG_W-1:0] STOP_T     = MAG_W'(STOP_THRESH);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CNT - 1);

  swing_state_t     state_q, state_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic [MAG_W-1:0] peak;
  logic [MAG_W-1:0] peak_with_sample;
  logic             is_quiet, arm, quiet_hit, timeout_hit;
  logic             load, update, clear, finish;

  assign is_quiet         = accel_mag < STOP_T;
  assign arm              = sample_valid && throw_en && (accel_mag >= START_T);
  assign quiet_hit        = is_quiet && (quiet_q == QUIET_LAST);
  assign peak_with_sample = (accel_mag > peak) ? accel_mag : peak;

  peak_tracker #(.W(MAG_W)) u_peak (
    .clk    (CLOCK_50),
    .rst    (reset),
    .load   (load),
    .update (update),
    .clear  (clear),
    .din    (accel_mag),
    .peak   (peak)
  );

`ifdef SWING_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_SAMPLES - 1);

  logic [CW-1:0] cnt_q;

  // Count follows the peak tracker's load/update/clear so both see the same samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(1);
    end else if (clear) begin
      cnt_q <= '0;
    end else if (update) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  logic unused_max_samples;
  assign unused_max_samples = ^MAX_SAMPLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
    end
  end

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    load    = 1'b0;
    update  = 1'b0;
    clear   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = SWING;
          quiet_d = '0;
          load    = 1'b1;
        end
      end
      SWING: begin
        if (!throw_en) begin
          state_d = IDLE;
          quiet_d = '0;
          clear   = 1'b1;
        end else if (sample_valid) begin
          if (quiet_hit || timeout_hit) begin
            state_d = IDLE;
            quiet_d = '0;
            clear   = 1'b1;
            finish  = 1'b1;
          end else begin
            update  = 1'b1;
            quiet_d = is_quiet ? quiet_q + QW'(1) : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ending sample is folded into the level so a timeout includes it.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pow_lvl   <= '0;
      pow_valid <= 1'b0;
    end else begin
      pow_valid <= finish;
      if (finish) begin
        pow_lvl <= peak_with_sample[MAG_W-1 -: POW_W];
      end
    end
  end

  assign swinging = (state_q == SWING);

endmodule

// File: tb/tb_swing_capture.sv
// Scoreboard bench for swing_capture: directed scenarios plus randomized traffic vs a sample-list model.
module tb_swing_capture;

  localparam int START = 64;
  localparam int STOP  = 32;
  localparam int QUIET = 4;
  localparam int MAXS  = 8;
`ifdef SWING_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] accel_mag = '0;
  logic       sample_valid = 1'b0;
  logic       throw_en = 1'b0;
  logic [2:0] pow_lvl;
  logic       pow_valid;
  logic       swinging;

  swing_capture #(
    .MAG_W(8), .START_THRESH(START), .STOP_THRESH(STOP),
    .QUIET_CNT(QUIET), .MAX_SAMPLES(MAXS)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .accel_mag    (accel_mag),
    .sample_valid (sample_valid),
    .throw_en     (throw_en),
    .pow_lvl      (pow_lvl),
    .pow_valid    (pow_valid),
    .swinging     (swinging)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the samples of the swing in progress, plus the last reported level.
  bit m_swing  = 1'b0;
  bit m_strobe = 1'b0;
  int m_lvl    = 0;
  int m_samples[$];
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trailing_quiet();
    int n = 0;
    for (int i = m_samples.size() - 1; i >= 0; i--) begin
      if (m_samples[i] >= STOP) break;
      n++;
    end
    return n;
  endfunction

  function automatic int max_sample();
    int m = 0;
    foreach (m_samples[i]) if (m_samples[i] > m) m = m_samples[i];
    return m;
  endfunction

  task automatic model_step(input bit v, input int mag, input bit ten);
    m_strobe = 1'b0;
    if (!m_swing) begin
      if (v && ten && mag >= START) begin
        m_swing = 1'b1;
        m_samples.delete();
        m_samples.push_back(mag);
      end
    end else if (!ten) begin
      m_swing = 1'b0;
      m_samples.delete();
    end else if (v) begin
      m_samples.push_back(mag);
      if (trailing_quiet() >= QUIET || (TIMEOUT && m_samples.size() >= MAXS)) begin
        m_lvl    = max_sample() / 32;
        m_strobe = 1'b1;
        exp_q.push_back(m_lvl);
        m_swing  = 1'b0;
        m_samples.delete();
      end
    end
  endtask

  task automatic step(input bit v, input int mag, input bit ten);
    @(negedge clk);
    sample_valid = v;
    accel_mag    = 8'(mag);
    throw_en     = ten;
    model_step(v, mag, ten);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    m_swing      = 1'b0;
    m_strobe     = 1'b0;
    m_lvl        = 0;
    m_samples.delete();
    exp_q.delete();
    #1;
    chk("async_rst_pow_lvl", int'(pow_lvl), 0);
    chk("async_rst_pow_valid", int'(pow_valid), 0);
    chk("async_rst_swinging", int'(swinging), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic play(input int seq[$]);
    foreach (seq[i]) step(1'b1, seq[i], 1'b1);
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each strobe.
  initial begin
    int exp_lvl;
    forever begin
      @(posedge clk);
      #1;
      chk("swinging", int'(swinging), int'(m_swing));
      chk("pow_valid", int'(pow_valid), int'(m_strobe));
      chk("pow_lvl_held", int'(pow_lvl), m_lvl);
      if (pow_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_lvl = exp_q.pop_front();
          chk("strobe_lvl", int'(pow_lvl), exp_lvl);
        end
      end
    end
  end

  initial begin
    int r;
    @(negedge clk);
    #1;
    chk("reset_pow_lvl", int'(pow_lvl), 0);
    chk("reset_pow_valid", int'(pow_valid), 0);
    chk("reset_swinging", int'(swinging), 0);
    @(negedge clk);
    reset = 1'b0;

    play('{70, 150, 200, 20, 10, 5, 3});
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    play('{50, 60});
    step(1'b0, 0, 1'b1);
    play('{100, 240, 40, 20, 20, 20, 20});
    step(1'b0, 0, 1'b1);
    step(1'b1, 180, 1'b1);
    step(1'b1, 90, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    // Gaps inside a swing never count as quiet.
    step(1'b1, 200, 1'b1);
    step(1'b1, 20, 1'b1);
    repeat (3) step(1'b0, 5, 1'b1);
    step(1'b1, 20, 1'b1);
    step(1'b1, 20, 1'b1);
    step(1'b0, 5, 1'b1);
    step(1'b1, 20, 1'b1);
    step(1'b0, 0, 1'b1);

    step(1'b1, 130, 1'b1);
    step(1'b1, 10, 1'b1);
    repeat (4) step(1'b0, 0, 1'b1);
    step(1'b1, 10, 1'b1);
    do_reset();

    play('{100, 100, 100, 100, 100, 100, 100, 100});
    play('{10, 10, 10, 10});
    step(1'b0, 0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0,
           (r == 0) ? $urandom_range(0, 31) : (r == 1) ? $urandom_range(32, 63) : $urandom_range(64, 255),
           $urandom_range(0, 19) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    repeat (3) step(1'b0, 0, 1'b1);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
